// File: rtl/curve25519_pkg.sv
// Shared constants and FSM encoding for the p = 2^255 - 19 reduction path.
package curve25519_pkg;
  localparam int N = 255;
  // 2^255 - 19: all ones above bit 4, low byte 0xED
  localparam logic [N-1:0] P25519 = {{(N-5){1'b1}}, 5'b01101};
  localparam int unsigned C19 = 19;

  typedef enum logic [2:0] {IDLE, FOLD1, FOLD2, FINAL, DONE} fold_state_t;
endpackage

// File: rtl/mul19_add.sv
// Combinational lo + 19*hi, using only shifts and adds.
module mul19_add #(
  parameter int LO_W  = 255,
  parameter int HI_W  = 255,
  parameter int OUT_W = 261
) (
  input  logic [LO_W-1:0]  lo,
  input  logic [HI_W-1:0]  hi,
  output logic [OUT_W-1:0] sum
);
  logic [OUT_W-1:0] h;

  assign h   = OUT_W'(hi);
  // 19 = 16 + 2 + 1; OUT_W is sized by the caller so nothing overflows
  assign sum = OUT_W'(lo) + (h << 4) + (h << 1) + h;
endmodule

// File: rtl/fold_reduce_p25519.sv
// Constant-latency reducer of a 2N-bit product modulo 2^255 - 19:
// two folds by 19, then one conditional subtract of p.
module fold_reduce_p25519 #(
  parameter int N = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] n,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   r,
  output logic           busy
);
  import curve25519_pkg::*;

  localparam int T1_W = N + 6;
  localparam int T2_W = N + 1;

  fold_state_t      state, state_nxt;
  logic [2*N-1:0]   t0;
  logic [T1_W-1:0]  t1, f1;
  logic [T2_W-1:0]  t2, f2;
  logic [N-1:0]     r_reg;
  logic [N+1:0]     d;

  mul19_add #(.LO_W(N), .HI_W(N), .OUT_W(T1_W)) u_fold1 (
    .lo (t0[N-1:0]),
    .hi (t0[2*N-1:N]),
    .sum(f1)
  );

  // t1 < 2^261, so its high part is at most 6 bits
  mul19_add #(.LO_W(N), .HI_W(T1_W-N), .OUT_W(T2_W)) u_fold2 (
    .lo (t1[N-1:0]),
    .hi (t1[T1_W-1:N]),
    .sum(f2)
  );

  // t2 < 2p, so a single subtract fully reduces; d[N+1] is the borrow
  assign d = {1'b0, t2} - {2'b00, P25519};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = FOLD1;
      FOLD1:   state_nxt = FOLD2;
      FOLD2:   state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      t0        <= '0;
      t1        <= '0;
      t2        <= '0;
      r_reg     <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == DONE);
      if (!abort) begin
        case (state)
          IDLE:    if (in_valid) t0 <= n;
          FOLD1:   t1 <= f1;
          FOLD2:   t2 <= f2;
          FINAL:   r_reg <= d[N+1] ? t2[N-1:0] : d[N-1:0];
          default: ;
        endcase
      end
    end
  end

  assign r        = r_reg;
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
endmodule
